// File: rtl/ntru_pkg.sv
// Shared constants for the ternary-by-Rq polynomial multiplier: default sizes,
// ternary coefficient encoding and the controller state type.
package ntru_pkg;

    localparam int unsigned NTRU_N      = 701;
    localparam int unsigned NTRU_Q_BITS = 13;
    localparam int unsigned TER_BITS    = 2;

    localparam logic [TER_BITS-1:0] TER_ZERO = 2'b00;
    localparam logic [TER_BITS-1:0] TER_POS  = 2'b01;
    localparam logic [TER_BITS-1:0] TER_NEG  = 2'b10;
    localparam logic [TER_BITS-1:0] TER_ILL  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/ter_mac.sv
// One accumulator lane: add, subtract or hold a Q_BITS coefficient under a
// ternary select. Wrap-around of the adder gives the mod 2^Q_BITS reduction.
module ter_mac
    import ntru_pkg::*;
#(
    parameter int unsigned Q_BITS = NTRU_Q_BITS
) (
    input  logic [Q_BITS-1:0]   acc_i,
    input  logic [Q_BITS-1:0]   h_i,
    input  logic [TER_BITS-1:0] sel_i,
    output logic [Q_BITS-1:0]   acc_o
);

    always_comb begin
        acc_o = acc_i;
        case (sel_i)
            TER_POS: acc_o = acc_i + h_i;
            TER_NEG: acc_o = acc_i - h_i;
            default: acc_o = acc_i;  // zero and the illegal code both hold
        endcase
    end

endmodule

// File: rtl/ter_rq_mul.sv
// Sequential product r*h in Z_q[x]/(x^N-1): one ternary coefficient of r per
// cycle is applied to all N lanes while h is rotated by x.
module ter_rq_mul
    import ntru_pkg::*;
#(
    parameter int unsigned N      = NTRU_N,
    parameter int unsigned Q_BITS = NTRU_Q_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TER_BITS*N-1:0] r_in,
    input  logic [Q_BITS*N-1:0]   h_in,
    output logic                  busy,
    output logic                  done,
    output logic [Q_BITS*N-1:0]   b_out
);

    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned RW    = TER_BITS * N;
    localparam int unsigned HW    = Q_BITS * N;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    r_q, r_d;
    logic [HW-1:0]    hrot_q, hrot_d;
    logic [HW-1:0]    acc_q, acc_d;
    logic [HW-1:0]    acc_mac;

    for (genvar k = 0; k < N; k++) begin : g_lane
        ter_mac #(
            .Q_BITS (Q_BITS)
        ) u_mac (
            .acc_i (acc_q[Q_BITS*k +: Q_BITS]),
            .h_i   (hrot_q[Q_BITS*k +: Q_BITS]),
            .sel_i (r_q[TER_BITS-1:0]),
            .acc_o (acc_mac[Q_BITS*k +: Q_BITS])
        );
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        r_d     = r_q;
        hrot_d  = hrot_q;
        acc_d   = acc_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    r_d     = r_in;
                    hrot_d  = h_in;
                    acc_d   = '0;
                end
            end
            StRun: begin
                acc_d = acc_mac;
                // Multiply by x: coefficient N-1 wraps around to position 0.
                hrot_d = {hrot_q[HW-Q_BITS-1:0], hrot_q[HW-1 -: Q_BITS]};
                r_d    = {{TER_BITS{1'b0}}, r_q[RW-1:TER_BITS]};
                if (cnt_q == LAST_STEP) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            r_q     <= '0;
            hrot_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            hrot_q  <= hrot_d;
            acc_q   <= acc_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign b_out = acc_q;

endmodule

// File: tb/tb_ter_rq_mul.sv
// Directed and random bench for ter_rq_mul: expected products are queued at
// start and compared, together with the start-to-done latency, at done.
module tb_ter_rq_mul;

    localparam int N  = 701;
    localparam int Q  = 13;
    localparam int RW = 2 * N;
    localparam int HW = Q * N;
    localparam int N_RANDOM = 30;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [RW-1:0] r_in;
    logic [HW-1:0] h_in;
    logic          busy;
    logic          done;
    logic [HW-1:0] b_out;

    ter_rq_mul #(
        .N      (N),
        .Q_BITS (Q)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .r_in  (r_in),
        .h_in  (h_in),
        .busy  (busy),
        .done  (done),
        .b_out (b_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int npass  = 0;
    int ntotal = 0;

    logic [HW-1:0] exp_q[$];
    int            start_q[$];

    // Independent reference: cyclic convolution with natural 13-bit wrap.
    function automatic logic [HW-1:0] ref_mul(input logic [RW-1:0] r, input logic [HW-1:0] h);
        logic [Q-1:0]  acc[N];
        logic [HW-1:0] res;
        logic [1:0]    t;
        for (int k = 0; k < N; k++) acc[k] = '0;
        for (int i = 0; i < N; i++) begin
            t = r[2*i +: 2];
            if (t == 2'b01 || t == 2'b10) begin
                for (int k = 0; k < N; k++) begin
                    if (t == 2'b01) acc[k] = acc[k] + h[Q*((k - i + N) % N) +: Q];
                    else            acc[k] = acc[k] - h[Q*((k - i + N) % N) +: Q];
                end
            end
        end
        for (int k = 0; k < N; k++) res[Q*k +: Q] = acc[k];
        return res;
    endfunction

    function automatic logic [HW-1:0] rand_h();
        logic [HW-1:0] h;
        for (int k = 0; k < N; k++) h[Q*k +: Q] = Q'($urandom_range(0, (1 << Q) - 1));
        return h;
    endfunction

    function automatic logic [RW-1:0] rand_r(input bit legal_only);
        logic [RW-1:0] r;
        for (int k = 0; k < N; k++)
            r[2*k +: 2] = legal_only ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntotal++;
        assert (obs === expv) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic check_b(input string tag, input logic [HW-1:0] expv);
        int idx;
        ntotal++;
        assert (b_out === expv) npass++;
        else begin
            idx = 0;
            for (int k = N - 1; k >= 0; k--)
                if (b_out[Q*k +: Q] !== expv[Q*k +: Q]) idx = k;
            $error("FAIL %s: b[%0d] observed %0d expected %0d", tag, idx,
                   b_out[Q*idx +: Q], expv[Q*idx +: Q]);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start-sampling edge.
    task automatic start_mul(input logic [RW-1:0] r, input logic [HW-1:0] h,
                             input logic [HW-1:0] expv, input bit hold_start);
        r_in  = r;
        h_in  = h;
        start = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        start_q.push_back(cyc);
        if (!hold_start) start = 1'b0;
        // Inputs are don't-care once sampled.
        r_in = rand_r(1'b0);
        h_in = rand_h();
    endtask

    task automatic finish_mul(input string tag);
        int            lat;
        int            s;
        logic [HW-1:0] expv;
        lat = -1;
        for (int c = 0; c < N + 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc - start_q[0];
                break;
            end
        end
        s    = start_q.pop_front();
        expv = exp_q.pop_front();
        check({tag, " latency"}, lat, N);
        check_b({tag, " product"}, expv);
        @(negedge clk);
        check({tag, " done pulse"}, {31'd0, done}, 0);
        check_b({tag, " hold"}, expv);
    endtask

    logic [RW-1:0] r;
    logic [HW-1:0] h;
    logic [HW-1:0] e;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        r_in  = '0;
        h_in  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 0);
        check("reset done", {31'd0, done}, 0);
        check_b("reset b_out", '0);
        rst = 1'b0;
        @(negedge clk);

        // Identity: r = 1
        r = '0;
        r[1:0] = 2'b01;
        h = rand_h();
        start_mul(r, h, h, 1'b0);
        check("identity busy", {31'd0, busy}, 1);
        finish_mul("identity");
        check("identity idle busy", {31'd0, busy}, 0);

        // r = x, h = 5*x^700 -> 5 wraps to coefficient 0
        r = '0;
        r[3:2] = 2'b01;
        h = '0;
        h[Q*700 +: Q] = 13'd5;
        e = '0;
        e[Q-1:0] = 13'd5;
        start_mul(r, h, e, 1'b0);
        finish_mul("wrap");

        // All -1 times h = 1 -> every coefficient is -1 mod 8192
        for (int k = 0; k < N; k++) r[2*k +: 2] = 2'b10;
        h = '0;
        h[Q-1:0] = 13'd1;
        for (int k = 0; k < N; k++) e[Q*k +: Q] = 13'd8191;
        start_mul(r, h, e, 1'b0);
        finish_mul("all minus one");

        // Illegal codes behave as zero
        for (int k = 0; k < N; k++) r[2*k +: 2] = 2'b11;
        start_mul(r, rand_h(), '0, 1'b0);
        finish_mul("illegal");

        // start held high: extra starts during RUN/DONE ignored
        r = rand_r(1'b1);
        h = rand_h();
        start_mul(r, h, ref_mul(r, h), 1'b1);
        repeat (100) @(negedge clk);
        check("held busy", {31'd0, busy}, 1);
        finish_mul("held start");
        // still high, so a second run begins from IDLE; abort it mid-way
        repeat (300) @(negedge clk);
        check("second run busy", {31'd0, busy}, 1);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {31'd0, busy}, 0);
        check("abort done", {31'd0, done}, 0);
        check_b("abort b_out", '0);
        @(negedge clk);
        check("post abort done", {31'd0, done}, 0);
        r = rand_r(1'b1);
        h = rand_h();
        start_mul(r, h, ref_mul(r, h), 1'b0);
        finish_mul("after abort");

        for (int n = 0; n < N_RANDOM; n++) begin
            r = rand_r(1'b1);
            h = rand_h();
            start_mul(r, h, ref_mul(r, h), 1'b0);
            finish_mul($sformatf("random %0d", n));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
